regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the single-write, two-read CPU register file. It adds N read ports, optional write-to-read bypass and a per-register pending-write scoreboard with a busy-count counter. It sits between decode/issue (reads, busy marking) and writeback (writes, busy clearing) of the pipelined core.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
NREAD, 2, number of combinational read ports
BYPASS, 1, 1 = a read of the register written this cycle returns wrData; 0 = returns old value
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all registers, busy bits and busyCount
wrEn  in  1  writeback valid
wrAddr  in  AW=$clog2(NREGS)  writeback register index
wrData  in  XLEN  writeback data
issueEn  in  1  mark a register as pending (instruction issued with destination)
issueAddr  in  AW  destination being marked
flush  in  1  pipeline flush: clears all busy bits, data untouched
rdAddr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
rdData  out  NREAD*XLEN  packed read data
rdBusy  out  NREAD  per-port busy flag of addressed register
busyCount  out  $clog2(NREGS+1)  number of registers currently busy

Behaviour:
- reset low (any time, asynchronous): all regs = 0, all busy = 0, busyCount = 0; rdData reflects zeros combinationally; no write/issue accepted while low.
- Write: wrEn at edge -> reg[wrAddr] <= wrData; busy[wrAddr] <= 0. ZERO_REG=1 and wrAddr=0 -> ignored entirely.
- Issue: issueEn at edge -> busy[issueAddr] <= 1. ZERO_REG=1 and issueAddr=0 -> ignored.
- Same edge, issueAddr == wrAddr, both enabled: data written AND busy ends 1 (new pending writer wins).
- flush at edge: all busy <= 0; takes priority over issueEn same cycle; concurrent wrEn data write still performed.
- Reads fully combinational, zero latency, NREAD independent ports, any addresses, duplicates allowed.
- rdData[i]: ZERO_REG=1 and addr 0 -> 0; else BYPASS=1 and wrEn and wrAddr==rdAddr[i] -> wrData; else reg[rdAddr[i]].
- rdBusy[i]: busy[rdAddr[i]]; with BYPASS=1 a same-cycle write to that addr forces rdBusy[i]=0 unless issueEn targets same addr (then 1 is not visible until next cycle; current rdBusy = 0 since data bypassed). addr 0 with ZERO_REG=1 -> 0.
- busyCount: registered; next = popcount(next busy vector); saturation impossible (max NREGS). Updated same edge as busy bits; equals popcount(busy) at all times after reset.
- Writes to non-busy registers legal (no error); issuing to already-busy register legal (stays busy, count unchanged).
- No other state; no X propagation from unwritten registers (reset guarantees defined values).

Decomposition:
- Package regfile_pkg: default XLEN/NREGS constants, AW derivation function, popcount function for busyCount next-state.
- One natural sub-module: regfile_read_port (one per NREAD via generate) implementing zero/bypass/busy mux for a single port.

Test Plan:
- Reset: drive reset low mid-run after writing reg5=0xDEADBEEF -> rdData for addr5 reads 0 immediately, busyCount=0, rdBusy=0.
- Write/read/bypass: wrEn addr3 data 0x12345678, rdAddr0=3 same cycle -> rdData0=0x12345678 (BYPASS=1), old value (BYPASS=0); next cycle both read 0x12345678.
- Zero register: wrEn addr0 data 0xFFFFFFFF, issueEn addr0 -> rdData 0, rdBusy 0, busyCount unchanged (ZERO_REG=1); with ZERO_REG=0 reads 0xFFFFFFFF.
- Scoreboard: issue 7, issue 9 -> busyCount 2, rdBusy for 7 =1; write 7 -> busyCount 1, rdBusy(7)=0; same-edge issue 9 + write 9 -> busy(9)=1, busyCount 1.
- Flush: busy {4,6,8}, flush with issueEn 10 and wrEn 4 data 0xAA -> busyCount 0, reg4=0xAA, busy(10)=0.
- Multi-port: NREAD=4, all ports address 2 plus ports on 0,31 -> identical data on duplicates, 0 on port at addr0, reg31 contents on last.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    // Widest busy vector popcount() accepts; larger NREGS would be truncated.
    localparam int unsigned MAX_REGS  = 256;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_REGS; i++) begin
            c += {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register, write bypass and busy masking.
module regfile_read_port
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
)
(
    input  logic [AW-1:0]   rdAddr,
    input  logic [XLEN-1:0] regData,
    input  logic            regBusy,
    input  logic            wrEn,
    input  logic [AW-1:0]   wrAddr,
    input  logic [XLEN-1:0] wrData,
    output logic [XLEN-1:0] rdData,
    output logic            rdBusy
);

    always_comb begin
        rdData = regData;
        rdBusy = regBusy;
        if (ZERO_REG != 0 && rdAddr == '0) begin
            rdData = '0;
            rdBusy = 1'b0;
        end else if (BYPASS != 0 && wrEn && wrAddr == rdAddr) begin
            // A same-cycle issue to this register only shows as busy next cycle.
            rdData = wrData;
            rdBusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with N read ports, write bypass and pending-write scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = addr_width(NREGS),
    localparam int unsigned CW      = $clog2(NREGS + 1)
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [AW-1:0]         wrAddr,
    input  logic [XLEN-1:0]       wrData,
    input  logic                  issueEn,
    input  logic [AW-1:0]         issueAddr,
    input  logic                  flush,
    input  logic [NREAD*AW-1:0]   rdAddr,
    output logic [NREAD*XLEN-1:0] rdData,
    output logic [NREAD-1:0]      rdBusy,
    output logic [CW-1:0]         busyCount
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_ok;
    logic             issue_ok;

    // Gating with reset keeps the bypass path quiet while reset is asserted.
    assign wr_ok    = reset && wrEn    && !(ZERO_REG != 0 && wrAddr    == '0);
    assign issue_ok = reset && issueEn && !(ZERO_REG != 0 && issueAddr == '0);

    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wrAddr] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (issue_ok) begin
            busy_nxt[issueAddr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            busyCount <= '0;
        end else begin
            if (wr_ok) begin
                regs[wrAddr] <= wrData;
            end
            busy      <= busy_nxt;
            busyCount <= CW'(popcount(MAX_REGS'(busy_nxt)));
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rdAddr[g*AW +: AW];

        regfile_read_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .rdAddr  (addr),
            .regData (regs[addr]),
            .regBusy (busy[addr]),
            .wrEn    (wr_ok),
            .wrAddr  (wrAddr),
            .wrData  (wrData),
            .rdData  (rdData[g*XLEN +: XLEN]),
            .rdBusy  (rdBusy[g])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two configurations (bypass+zero-reg, plain) driven in lockstep.
module tb_regfile_scoreboard;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         wrEn = 1'b0;
    logic [4:0]   wrAddr = '0;
    logic [31:0]  wrData = '0;
    logic         issueEn = 1'b0;
    logic [4:0]   issueAddr = '0;
    logic         flush = 1'b0;
    logic [19:0]  rdAddr = '0;
    logic [127:0] rdData_a, rdData_b;
    logic [3:0]   rdBusy_a, rdBusy_b;
    logic [5:0]   busyCount_a, busyCount_b;

    always #5 clock = ~clock;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(4), .BYPASS(1), .ZERO_REG(1)) u_a (
        .clock(clock), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .issueEn(issueEn), .issueAddr(issueAddr), .flush(flush), .rdAddr(rdAddr),
        .rdData(rdData_a), .rdBusy(rdBusy_a), .busyCount(busyCount_a));

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(4), .BYPASS(0), .ZERO_REG(0)) u_b (
        .clock(clock), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .issueEn(issueEn), .issueAddr(issueAddr), .flush(flush), .rdAddr(rdAddr),
        .rdData(rdData_b), .rdBusy(rdBusy_b), .busyCount(busyCount_b));

    typedef struct packed {
        logic [3:0][31:0] da;
        logic [3:0][31:0] db;
        logic [3:0]       ba;
        logic [3:0]       bb;
        logic [5:0]       ca;
        logic [5:0]       cb;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    // Reference state: a = bypass + hardwired r0, b = no bypass, r0 ordinary.
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    bit          ka [32];
    bit          kb [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("a.rdData[%0d]", p), rdData_a[p*32 +: 32], e.da[p]);
                chk($sformatf("b.rdData[%0d]", p), rdData_b[p*32 +: 32], e.db[p]);
            end
            chk("a.rdBusy", {28'b0, rdBusy_a}, {28'b0, e.ba});
            chk("b.rdBusy", {28'b0, rdBusy_b}, {28'b0, e.bb});
            chk("a.busyCount", {26'b0, busyCount_a}, {26'b0, e.ca});
            chk("b.busyCount", {26'b0, busyCount_b}, {26'b0, e.cb});
        end
    end

    task automatic step(input bit rs, input bit we, input int wa, input logic [31:0] wd,
                        input bit ie, input int ia, input bit fl,
                        input int r0, input int r1, input int r2, input int r3);
        exp_t e;
        int   ra [4];
        int   na, nb;
        ra = '{r0, r1, r2, r3};
        reset = rs; wrEn = we; wrAddr = 5'(wa); wrData = wd;
        issueEn = ie; issueAddr = 5'(ia); flush = fl;
        rdAddr = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
        if (!rs) begin
            for (int i = 0; i < 32; i++) begin
                ma[i] = '0; mb[i] = '0; ka[i] = 0; kb[i] = 0;
            end
        end
        e = '0;
        for (int p = 0; p < 4; p++) begin
            int a;
            a = ra[p];
            if (a == 0) begin
                e.da[p] = '0; e.ba[p] = 1'b0;
            end else if (rs && we && wa == a) begin
                e.da[p] = wd; e.ba[p] = 1'b0;
            end else begin
                e.da[p] = ma[a]; e.ba[p] = ka[a];
            end
            e.db[p] = mb[a];
            e.bb[p] = kb[a];
        end
        na = 0; nb = 0;
        for (int i = 0; i < 32; i++) begin
            na += int'(ka[i]); nb += int'(kb[i]);
        end
        e.ca = 6'(na); e.cb = 6'(nb);
        q.push_back(e);
        @(posedge clock); #1;
        if (rs) begin
            if (we) begin
                if (wa != 0) begin ma[wa] = wd; ka[wa] = 0; end
                mb[wa] = wd; kb[wa] = 0;
            end
            if (fl) begin
                for (int i = 0; i < 32; i++) begin ka[i] = 0; kb[i] = 0; end
            end else if (ie) begin
                if (ia != 0) ka[ia] = 1;
                kb[ia] = 1;
            end
        end
    endtask

    task automatic rd(input int r0, input int r1, input int r2, input int r3);
        step(1, 0, 0, '0, 0, 0, 0, r0, r1, r2, r3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock); #1;
        step(0, 0, 0, '0, 0, 0, 0, 0, 1, 5, 31);
        rd(1, 2, 3, 4);
        // mid-run reset clears data immediately and blocks writes while low
        step(1, 1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 5, 0, 1);
        rd(5, 5, 0, 1);
        step(0, 1, 5, 32'h1111_1111, 1, 5, 0, 5, 5, 0, 1);
        step(0, 1, 5, 32'h2222_2222, 1, 6, 0, 5, 6, 0, 1);
        rd(5, 6, 0, 1);
        // write + same-cycle read, then next-cycle read
        step(1, 1, 3, 32'h12345678, 0, 0, 0, 3, 3, 2, 0);
        rd(3, 3, 2, 0);
        // register 0 handling
        step(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 3, 1);
        rd(0, 0, 3, 1);
        // scoreboard
        step(1, 0, 0, '0, 1, 7, 0, 7, 9, 0, 3);
        step(1, 0, 0, '0, 1, 9, 0, 7, 9, 0, 3);
        step(1, 1, 7, 32'h0000_0777, 0, 0, 0, 7, 9, 0, 3);
        step(1, 1, 9, 32'h0000_0999, 1, 9, 0, 7, 9, 0, 3);
        rd(7, 9, 0, 3);
        // flush beats issue, concurrent write still lands
        step(1, 0, 0, '0, 1, 4, 0, 4, 6, 8, 10);
        step(1, 0, 0, '0, 1, 6, 0, 4, 6, 8, 10);
        step(1, 0, 0, '0, 1, 8, 0, 4, 6, 8, 10);
        step(1, 1, 4, 32'h0000_00AA, 1, 10, 1, 4, 6, 8, 10);
        rd(4, 6, 8, 10);
        // multi-port duplicates and extremes
        step(1, 1, 2, 32'hCAFE_0002, 0, 0, 0, 2, 2, 2, 2);
        step(1, 1, 31, 32'hBEEF_0031, 1, 31, 0, 2, 2, 0, 31);
        rd(2, 2, 0, 31);
        for (int n = 0; n < 300; n++) begin
            int  wa, ia, r[4];
            bit  rs;
            wa = int'($urandom_range(0, 31));
            ia = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++)
                r[p] = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 31));
            rs = ($urandom_range(0, 96) != 0);
            step(rs, 1'($urandom_range(0, 1)), wa, $urandom, ($urandom_range(0, 2) == 0), ia,
                 ($urandom_range(0, 15) == 0), r[0], r[1], r[2], r[3]);
        end
        rd(0, 1, 30, 31);
        @(negedge clock); #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
